// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The slave modport is the cache's view of the bus; the master modport is the datapath/memory view.
interface icache_direct_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with one-word frames.
// Hits answer combinationally; misses stall the datapath and refill one word from memory.
module icache_direct #(
    parameter int unsigned SETS = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    icache_direct_if.slave  io_cif
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS];
    logic [29:0]      r_miss_word;
    logic [31:0]      r_hit_count;
    logic [31:0]      r_miss_count;

    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    logic             w_lookup_hit;
    logic             w_ihit;
    logic [31:0]      w_imemload;
    logic             w_iren;
    logic [31:0]      w_iaddr;
    logic             w_miss;
    logic             w_fill;
    logic             w_unused;

    assign w_tag        = io_cif.imemaddr[31:IDX_W+2];
    assign w_idx        = io_cif.imemaddr[IDX_W+1:2];
    assign w_fill_idx   = r_miss_word[IDX_W-1:0];
    assign w_fill_tag   = r_miss_word[29:IDX_W];
    assign w_lookup_hit = io_cif.imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_unused     = ^io_cif.imemaddr[1:0];

    // State register
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and fetch/memory outputs
    always_comb begin
        w_state_nxt = r_state;
        w_ihit      = 1'b0;
        w_imemload  = 32'd0;
        w_iren      = 1'b0;
        w_iaddr     = 32'd0;
        w_miss      = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ihit = w_lookup_hit;
                if (w_lookup_hit) begin
                    w_imemload = r_data[w_idx];
                end
                if (io_cif.imemREN && !w_lookup_hit) begin
                    w_miss      = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_iren  = 1'b1;
                w_iaddr = {r_miss_word, 2'b00};
                if (!io_cif.iwait) begin
                    w_fill      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Valid bits and miss address; reset invalidates every frame
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_valid     <= '0;
            r_miss_word <= 30'd0;
        end else begin
            if (w_miss) begin
                r_miss_word <= io_cif.imemaddr[31:2];
            end
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are qualified by the valid bits, so they carry no reset
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= io_cif.iload;
        end
    end

    // Performance counters wrap naturally at 2^32
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_ihit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign io_cif.ihit       = w_ihit;
    assign io_cif.imemload   = w_imemload;
    assign io_cif.iREN       = w_iren;
    assign io_cif.iaddr      = w_iaddr;
    assign io_cif.hit_count  = r_hit_count;
    assign io_cif.miss_count = r_miss_count;
endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: directed cases plus a random fetch stream
// checked against a residency model of the direct-mapped cache.
module tb_icache_direct;
    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    icache_direct_if cif();

    icache_direct #(.SETS(16)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .io_cif (cif.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: which word address each frame holds
    bit          rv [16];
    logic [29:0] rw [16];
    logic [31:0] m_hits;
    logic [31:0] m_misses;
    logic [31:0] exp_q  [$];
    logic [31:0] miss_q [$];
    int          forced_wait = -1;
    int          last_wait   = 0;

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C22_0004;
        if (a == 32'h0000_0080) return 32'h2001_0001;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) rv[i] = 1'b0;
        m_hits   = 32'd0;
        m_misses = 32'd0;
        exp_q.delete();
        miss_q.delete();
    endfunction

    // Record a request in the model; returns 1 if it should hit
    function automatic bit model_request(input logic [31:0] a, input bit completes);
        logic [29:0] w;
        int          idx;
        bit          hit;
        w   = a[31:2];
        idx = int'(w % 30'd16);
        hit = rv[idx] && (rw[idx] == w);
        if (!hit) begin
            miss_q.push_back({w, 2'b00});
            rv[idx] = 1'b1;
            rw[idx] = w;
            m_misses++;
        end
        if (completes) begin
            exp_q.push_back(mem_data({w, 2'b00}));
            m_hits++;
        end
        return hit;
    endfunction

    task automatic check_counters(input string tag);
        chk32({tag, "_hit_count"},  cif.hit_count,  m_hits);
        chk32({tag, "_miss_count"}, cif.miss_count, m_misses);
    endtask

    // Issue one fetch and hold it until ihit; optionally check the stall length
    task automatic fetch(input logic [31:0] a, input bit chk_lat);
        bit hit;
        bit got;
        int cyc;
        @(posedge CLK); #1;
        hit = model_request(a, 1'b1);
        cif.imemREN  = 1'b1;
        cif.imemaddr = a;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 60) begin
            @(negedge CLK);
            if (cif.ihit) got = 1'b1;
            else cyc++;
        end
        if (!got) fail("fetch_timeout");
        else if (chk_lat) chk32("fetch_latency", 32'(cyc), hit ? 32'd0 : 32'(last_wait + 2));
    endtask

    task automatic idle(input int n);
        @(posedge CLK); #1;
        cif.imemREN  = 1'b0;
        cif.imemaddr = $urandom;
        repeat (n) @(negedge CLK);
        chk32("idle_ihit", 32'(cif.ihit), 32'd0);
        check_counters("idle");
    endtask

    // Monitor: every hit cycle consumes one expected instruction
    always @(negedge CLK) begin
        if (nRST === 1'b0) begin
            if (cif.ihit) begin
                if (exp_q.size() == 0) fail("unexpected_ihit");
                else chk32("imemload", cif.imemload, exp_q.pop_front());
                chk32("iren_during_hit", 32'(cif.iREN), 32'd0);
            end else if (cif.imemload !== 32'd0) begin
                chk32("imemload_without_hit", cif.imemload, 32'd0);
            end
        end
    end

    // Memory responder: checks each request address against the model's miss queue
    initial begin : responder
        bit          busy;
        int          cnt;
        int          n;
        logic [31:0] cur;
        busy = 1'b0;
        cnt  = 0;
        n    = 0;
        cur  = 32'd0;
        cif.iwait = 1'b1;
        cif.iload = 32'd0;
        forever begin
            @(negedge CLK);
            if (nRST !== 1'b0) begin
                busy = 1'b0;
                cif.iwait = 1'b1;
            end else if (cif.iREN) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                    if (miss_q.size() == 0) begin
                        fail("unexpected_iren");
                        cur = cif.iaddr;
                    end else begin
                        cur = miss_q.pop_front();
                    end
                    n = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
                    last_wait = n;
                end
                chk32("iaddr", cif.iaddr, cur);
                if (cnt < n) begin
                    cif.iwait = 1'b1;
                    cif.iload = $urandom;
                    cnt++;
                end else begin
                    cif.iwait = 1'b0;
                    cif.iload = mem_data(cur);
                    busy = 1'b0;
                end
            end else begin
                cif.iwait = 1'($urandom_range(0, 1));
                cif.iload = $urandom;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] a;
        model_reset();
        nRST         = 1'b1;
        cif.imemREN  = 1'b1;
        cif.imemaddr = 32'h0000_0040;
        #12;
        chk32("rst_iren",     32'(cif.iREN), 32'd0);
        chk32("rst_iaddr",    cif.iaddr,     32'd0);
        chk32("rst_ihit",     32'(cif.ihit), 32'd0);
        chk32("rst_imemload", cif.imemload,  32'd0);
        check_counters("rst");
        cif.imemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b0;

        // Cold miss with three memory wait cycles, then repeat hits
        forced_wait = 3;
        fetch(32'h0000_0040, 1'b1);
        idle(1);
        forced_wait = -1;
        fetch(32'h0000_0040, 1'b1);
        fetch(32'h0000_0043, 1'b1);
        idle(1);

        // Conflict eviction in frame 0
        forced_wait = 2;
        fetch(32'h0000_0080, 1'b1);
        fetch(32'h0000_0040, 1'b1);
        idle(1);
        chk32("conflict_miss_count", cif.miss_count, 32'd3);

        // Address change while the fill for 0x10 is outstanding
        forced_wait = 3;
        @(posedge CLK); #1;
        void'(model_request(32'h0000_0010, 1'b0));
        cif.imemREN  = 1'b1;
        cif.imemaddr = 32'h0000_0010;
        fetch(32'h0000_0014, 1'b0);
        fetch(32'h0000_0010, 1'b1);
        idle(1);

        // Reset asserted between edges during a fetch
        forced_wait = 5;
        @(posedge CLK); #1;
        void'(model_request(32'h0000_0200, 1'b0));
        cif.imemREN  = 1'b1;
        cif.imemaddr = 32'h0000_0200;
        @(posedge CLK); #1;
        @(posedge CLK); #2;
        chk32("pre_reset_iren", 32'(cif.iREN), 32'd1);
        nRST        = 1'b1;
        cif.imemREN = 1'b0;
        #1;
        chk32("midfetch_rst_iren",  32'(cif.iREN), 32'd0);
        chk32("midfetch_rst_ihit",  32'(cif.ihit), 32'd0);
        chk32("midfetch_rst_iaddr", cif.iaddr,     32'd0);
        model_reset();
        check_counters("midfetch_rst");
        @(negedge CLK);
        nRST = 1'b0;
        forced_wait = 2;
        fetch(32'h0000_0040, 1'b1);
        idle(1);

        // Hit counter wrap
        forced_wait = -1;
        force dut.r_hit_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_hit_count;
        m_hits = 32'hFFFF_FFFF;
        fetch(32'h0000_0040, 1'b1);
        idle(1);
        chk32("wrap_hit_count", cif.hit_count, 32'd0);

        // Random fetch stream
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle(int'($urandom_range(1, 3)));
            end else begin
                a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                    | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) a = a | 32'h8000_0000;
                fetch(a, 1'b1);
            end
        end
        idle(2);
        chk32("exp_q_drained",  32'(exp_q.size()),  32'd0);
        chk32("miss_q_drained", 32'(miss_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache.
- Sits directly upstream of the single-cycle datapath. It answers the datapath's instruction fetch request (imemREN/imemaddr) with ihit/imemload.
- On a miss it stalls the datapath and fills the frame from memory over an iREN/iwait word handshake.
- Keeps hit and miss event counters for performance reporting.

Parameters:
- SETS, 16, number of one-word frames; power of two, minimum 2.
- IDX_W, log2(SETS) = 4, index width.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  reset: asynchronous, active-high. The block is in reset while nRST=1.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  fetched word valid this cycle.
- imemload  out  32  fetched instruction.
- iREN  out  1  memory read request.
- iaddr  out  32  memory read address, word aligned.
- iwait  in  1  memory busy; iload is valid in a cycle where iREN=1 and iwait=0.
- iload  in  32  memory read data.
- hit_count  out  32  number of hit cycles.
- miss_count  out  32  number of misses started.

Behaviour:
- Address split:
  - tag = addr[31:IDX_W+2]
  - index = addr[IDX_W+1:2]
  - offset = addr[1:0], ignored.
- Storage per frame: valid bit, tag, 32-bit data.
- Reset (nRST=1, takes effect immediately, independent of CLK):
  - all valid bits 0; state=IDLE.
  - miss address register = 0.
  - hit_count = 0, miss_count = 0.
  - While in reset: iREN=0, iaddr=0, ihit=0, imemload=0.
  - Tag and data arrays need not be cleared.
- State IDLE:
  - hit = imemREN & valid[index] & (tag[index]==tag). Combinational, 0-cycle latency.
  - ihit = hit; imemload = data[index] when hit, else 0.
  - iREN=0, iaddr=0.
  - On a clock edge with imemREN=1 and hit=0: latch {imemaddr[31:2],2'b00} into the miss address register, miss_count += 1, go to FETCH.
  - Edges with hit=1: hit_count += 1.
  - imemREN=0: no state change, no count.
- State FETCH:
  - iREN=1, iaddr = latched miss address; ihit=0, imemload=0.
  - Edges with iwait=1: hold in FETCH.
  - Edge with iwait=0: write frame[latched index] = {valid=1, latched tag, iload}; go to IDLE.
  - The next cycle re-evaluates imemaddr and hits if unchanged.
  - Miss latency: memory wait cycles + 1 fill cycle + 0 (hit).
  - No forwarding of iload to imemload during FETCH.
- imemaddr change or imemREN drop during FETCH:
  - The fetch completes with the latched address; the memory request is never aborted.
  - The filled frame stays valid even if no longer requested.
- Conflict miss: the fill overwrites the frame regardless of its prior valid/tag. No write-back (read-only cache).
- Counters: 32-bit unsigned, wrap 0xFFFFFFFF -> 0. No saturation.
- Reset asserted mid-FETCH:
  - iREN drops asynchronously; no frame is written.
  - After release, the cache starts from IDLE with all frames invalid.
- No self-modifying-code coherence: stores to instruction memory are not observed.

Test Plan:
1. Cold miss:
   - Stimulus: hold nRST=1, release; imemREN=1, imemaddr=0x00000040; memory returns iload=0x8C220004 after iwait=1 for 3 cycles.
   - Required: iREN=1, iaddr=0x00000040 for 4 cycles; ihit=1 with imemload=0x8C220004 on the following cycle; miss_count=1, hit_count increments from then on.
2. Repeat hit:
   - Stimulus: after scenario 1, request 0x00000040 then 0x00000043.
   - Required: both give ihit=1 in the same cycle, imemload=0x8C220004, iREN stays 0.
3. Conflict eviction:
   - Stimulus: fill 0x00000040, then request 0x00000080 (same index 0, different tag) with iload=0x20010001, then 0x00000040 again.
   - Required: 0x80 misses and refills; 0x40 misses again; miss_count=3.
4. Address change mid-fetch:
   - Stimulus: miss on 0x00000010, iwait=1; switch imemaddr to 0x00000014 on the next cycle.
   - Required: iaddr stays 0x00000010 until the fill. Then 0x14 misses, and a later request for 0x10 hits.
5. Reset mid-fetch:
   - Stimulus: during FETCH with iwait=1, assert nRST=1 between clock edges.
   - Required: iREN=0 and ihit=0 immediately; after release, the previously filled address misses; both counters read 0.
6. Counter wrap:
   - Stimulus: force hit_count=0xFFFFFFFF, then one hit cycle.
   - Required: hit_count=0x00000000; miss_count unchanged.
